// File: rtl/tipi_serial_regfile_pkg.sv
// tipi_serial_regfile_pkg
// Shared definitions for the TI<->RPi mailbox register file:
//   - register index constants for the classic four-register map
//   - default direction mask (TC/TD are TI-originated)
//   - serial transfer state encoding
//   - helper to look up a register's direction in a mask
package tipi_serial_regfile_pkg;

  localparam int TIPI_RC = 0;
  localparam int TIPI_RD = 1;
  localparam int TIPI_TC = 2;
  localparam int TIPI_TD = 3;

  // Bit i set: register i is written by the TI and read by the RPi.
  localparam logic [3:0] TIPI_TI_MASK_DEFAULT =
    4'((1 << TIPI_TC) | (1 << TIPI_TD));

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tipi_state_e;

  // Direction lookup; indices beyond the mask read as RPi-originated.
  function automatic logic mask_bit(input logic [31:0] mask,
                                    input int unsigned idx);
    logic [31:0] s;
    s = mask >> idx;
    return s[0];
  endfunction

endpackage

// File: rtl/tipi_serial_regfile_if.sv
// tipi_serial_regfile_if
// Bundles the RPi serial link and the TI parallel port.
//   master: drives r_sel/r_en/r_dout/r_le/r_err_clr and ti_we/ti_re/ti_idx/
//           ti_wdata; observes r_din/r_err/ti_rdata/ti_pending/dbg_state.
//   slave : the register file side (directions reversed).
// Handshake: there is no backpressure. r_en moves one bit per cycle it is
// high, r_le is a single-cycle end strobe, ti_we/ti_re are single-cycle
// pulses; every effect is visible on the cycle after the strobe.
interface tipi_serial_regfile_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int SELW  = 2
);
  logic [SELW-1:0]  r_sel;
  logic             r_en;
  logic             r_dout;
  logic             r_le;
  logic             r_din;
  logic             r_err_clr;
  logic             r_err;
  logic             ti_we;
  logic             ti_re;
  logic [SELW-1:0]  ti_idx;
  logic [WIDTH-1:0] ti_wdata;
  logic [WIDTH-1:0] ti_rdata;
  logic [NREG-1:0]  ti_pending;
  tipi_serial_regfile_pkg::tipi_state_e dbg_state;

  modport master (
    output r_sel, r_en, r_dout, r_le, r_err_clr,
    output ti_we, ti_re, ti_idx, ti_wdata,
    input  r_din, r_err, ti_rdata, ti_pending, dbg_state
  );

  modport slave (
    input  r_sel, r_en, r_dout, r_le, r_err_clr,
    input  ti_we, ti_re, ti_idx, ti_wdata,
    output r_din, r_err, ti_rdata, ti_pending, dbg_state
  );
endinterface

// File: rtl/tipi_shift_engine.sv
// tipi_shift_engine
// Serial side of the mailbox: shifter, bit counter, running parity,
// latched select, framing/overrun/abort error detection and sticky r_err.
// Ports:
//   clk, rst           clock, async active-high reset
//   r_sel_i .. r_err_clr_i  RPi serial link inputs
//   snap_i             current contents of register r_sel_i (loaded on the
//                      first bit of a TI-originated transfer)
//   r_din_o, r_err_o   serial return bit, sticky error
//   commit_o           r_le accepted with a full word this cycle
//   commit_sel_o       register being committed
//   commit_data_o      received word (meaningful for RPi-originated regs)
//   state_o            transfer state
module tipi_shift_engine
  import tipi_serial_regfile_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter int              NREG    = 4,
  parameter int              SELW    = 2,
  parameter logic [NREG-1:0] TI_MASK = TIPI_TI_MASK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  r_sel_i,
  input  logic             r_en_i,
  input  logic             r_dout_i,
  input  logic             r_le_i,
  input  logic             r_err_clr_i,
  input  logic [WIDTH-1:0] snap_i,
  output logic             r_din_o,
  output logic             r_err_o,
  output logic             commit_o,
  output logic [SELW-1:0]  commit_sel_o,
  output logic [WIDTH-1:0] commit_data_o,
  output tipi_state_e      state_o
);
  localparam int CW = $clog2(WIDTH + 1);

  tipi_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             din_q, din_d;
  logic             err_q, err_d;

  logic             err_set;
  logic             full;
  logic [SELW-1:0]  act_sel;
  logic             act_ti;
  logic [WIDTH-1:0] src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      sel_q   <= '0;
      din_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    sel_d    = sel_q;
    din_d    = din_q;
    err_set  = 1'b0;
    commit_o = 1'b0;

    full    = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH));
    // In IDLE the incoming select decides the direction of the new transfer.
    act_sel = (state_q == ST_IDLE) ? r_sel_i : sel_q;
    act_ti  = mask_bit(32'(TI_MASK), 32'(act_sel));
    // TI-originated transfers start from a snapshot, later bits from the shifter.
    src     = (state_q == ST_IDLE) ? snap_i : sh_q;

    if ((state_q == ST_SHIFT) && (r_sel_i != sel_q)) begin
      // Selection moved mid-transfer: abort, even if r_le is also high.
      state_d = ST_IDLE;
      cnt_d   = '0;
      par_d   = 1'b0;
      err_set = 1'b1;
    end else if (r_le_i) begin
      if (full) commit_o = 1'b1;
      else      err_set  = 1'b1;
      state_d = ST_IDLE;
      cnt_d   = '0;
      par_d   = 1'b0;
    end else if (r_en_i) begin
      if (full) begin
        err_set = 1'b1;
      end else begin
        state_d = ST_SHIFT;
        sel_d   = act_sel;
        cnt_d   = cnt_q + 1'b1;
        if (act_ti) begin
          din_d = src[WIDTH-1];
          sh_d  = {src[WIDTH-2:0], 1'b0};
          par_d = par_q ^ src[WIDTH-1];
        end else begin
          sh_d  = {sh_q[WIDTH-2:0], r_dout_i};
          par_d = par_q ^ r_dout_i;
          din_d = par_q ^ r_dout_i;
        end
      end
    end

    // A new error outranks a clear in the same cycle.
    if (err_set)          err_d = 1'b1;
    else if (r_err_clr_i) err_d = 1'b0;
    else                  err_d = err_q;
  end

  assign r_din_o       = din_q;
  assign r_err_o       = err_q;
  assign commit_sel_o  = sel_q;
  assign commit_data_o = sh_q;
  assign state_o       = state_q;

endmodule

// File: rtl/tipi_serial_regfile.sv
// tipi_serial_regfile
// Mailbox register file between a TI (parallel port) and an RPi (serial
// link). Holds NREG registers of WIDTH bits with a fixed direction each,
// a pending flag per register, and the TI read data register.
// Ports:
//   r_clk  sole clock
//   r_rst  asynchronous active-high reset
//   bus    tipi_serial_regfile_if.slave (RPi serial link + TI port + state)
module tipi_serial_regfile
  import tipi_serial_regfile_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter int              NREG    = 4,
  parameter int              SELW    = 2,
  parameter logic [NREG-1:0] TI_MASK = TIPI_TI_MASK_DEFAULT
) (
  input  logic r_clk,
  input  logic r_rst,
  tipi_serial_regfile_if.slave bus
);
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [WIDTH-1:0] snap;
  logic             commit;
  logic [SELW-1:0]  commit_sel;
  logic [WIDTH-1:0] commit_data;

  tipi_shift_engine #(
    .WIDTH(WIDTH), .NREG(NREG), .SELW(SELW), .TI_MASK(TI_MASK)
  ) u_engine (
    .clk          (r_clk),
    .rst          (r_rst),
    .r_sel_i      (bus.r_sel),
    .r_en_i       (bus.r_en),
    .r_dout_i     (bus.r_dout),
    .r_le_i       (bus.r_le),
    .r_err_clr_i  (bus.r_err_clr),
    .snap_i       (snap),
    .r_din_o      (bus.r_din),
    .r_err_o      (bus.r_err),
    .commit_o     (commit),
    .commit_sel_o (commit_sel),
    .commit_data_o(commit_data),
    .state_o      (bus.dbg_state)
  );

  // Snapshot of the register the RPi is selecting; zero when out of range.
  always_comb begin
    snap = '0;
    for (int i = 0; i < NREG; i++)
      if (SELW'(i) == bus.r_sel) snap = regs_q[i];
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  // Clears are applied before sets so a set in the same cycle wins.
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    pend_d  = pend_q;
    rdata_d = rdata_q;

    if (bus.ti_re) rdata_d = '0;

    for (int i = 0; i < NREG; i++) begin
      if (bus.ti_re && (SELW'(i) == bus.ti_idx)) begin
        rdata_d = regs_q[i];
        if (!TI_MASK[i]) pend_d[i] = 1'b0;
      end
      if (commit && (SELW'(i) == commit_sel) && TI_MASK[i])
        pend_d[i] = 1'b0;
    end

    for (int i = 0; i < NREG; i++) begin
      if (commit && (SELW'(i) == commit_sel) && !TI_MASK[i]) begin
        regs_d[i] = commit_data;
        pend_d[i] = 1'b1;
      end
      if (bus.ti_we && (SELW'(i) == bus.ti_idx) && TI_MASK[i]) begin
        regs_d[i] = bus.ti_wdata;
        pend_d[i] = 1'b1;
      end
    end
  end

  assign bus.ti_rdata   = rdata_q;
  assign bus.ti_pending = pend_q;

endmodule

// File: tb/tb_tipi_serial_regfile.sv
// tb_tipi_serial_regfile
// Randomized and directed stimulus against a behavioural model of the
// mailbox; every cycle the model's outputs are compared with the DUT.
module tb_tipi_serial_regfile;
  import tipi_serial_regfile_pkg::*;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic r_rst;
  always #5 clk = ~clk;

  tipi_serial_regfile_if #(.WIDTH(W), .NREG(N), .SELW(S)) bus ();

  tipi_serial_regfile #(.WIDTH(W), .NREG(N), .SELW(S), .TI_MASK(4'b1100)) dut (
    .r_clk(clk),
    .r_rst(r_rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]   ti_mask = 4'b1100;
  logic [W-1:0] m_reg [N];
  logic [N-1:0] m_pend;
  logic         m_err, m_din, m_busy;
  logic [W-1:0] m_rdata, m_snap, word;
  logic [S-1:0] m_sel;
  int           m_bits;
  logic         rx_q[$];
  logic         err_set, p;

  always @(posedge clk) begin
    if (r_rst) begin
      for (int i = 0; i < N; i++) m_reg[i] = '0;
      m_pend = '0; m_err = 0; m_din = 0; m_busy = 0; m_rdata = '0;
      m_bits = 0; m_sel = '0; rx_q.delete();
    end else begin
      err_set = 0;
      // TI read sees the register value from before this edge.
      if (bus.ti_re) begin
        m_rdata = (int'(bus.ti_idx) < N) ? m_reg[bus.ti_idx] : '0;
        if (int'(bus.ti_idx) < N && !ti_mask[bus.ti_idx]) m_pend[bus.ti_idx] = 0;
      end
      if (m_busy && bus.r_sel != m_sel) begin
        err_set = 1; m_busy = 0; m_bits = 0;
      end else if (bus.r_le) begin
        if (m_busy && m_bits == W) begin
          if (ti_mask[m_sel]) m_pend[m_sel] = 0;
          else begin
            word = '0;
            foreach (rx_q[i]) word = {word[W-2:0], rx_q[i]};
            m_reg[m_sel] = word;
            m_pend[m_sel] = 1;
          end
        end else err_set = 1;
        m_busy = 0; m_bits = 0;
      end else if (bus.r_en) begin
        if (m_busy && m_bits == W) err_set = 1;
        else begin
          if (!m_busy) begin
            m_busy = 1; m_sel = bus.r_sel; m_snap = m_reg[bus.r_sel]; rx_q.delete();
          end
          m_bits++;
          if (ti_mask[m_sel]) m_din = m_snap[W - m_bits];
          else begin
            rx_q.push_back(bus.r_dout);
            p = 0;
            foreach (rx_q[i]) p ^= rx_q[i];
            m_din = p;
          end
        end
      end
      if (bus.ti_we && int'(bus.ti_idx) < N && ti_mask[bus.ti_idx]) begin
        m_reg[bus.ti_idx] = bus.ti_wdata;
        m_pend[bus.ti_idx] = 1;
      end
      if (err_set) m_err = 1;
      else if (bus.r_err_clr) m_err = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started && !r_rst) begin
      check("r_din", 32'(bus.r_din), 32'(m_din));
      check("r_err", 32'(bus.r_err), 32'(m_err));
      check("ti_rdata", 32'(bus.ti_rdata), 32'(m_rdata));
      check("ti_pending", 32'(bus.ti_pending), 32'(m_pend));
      check("busy", 32'(bus.dbg_state == ST_SHIFT), 32'(m_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic dout, input logic le,
                       input logic [S-1:0] sel, input logic clr,
                       input logic we, input logic re,
                       input logic [S-1:0] idx, input logic [W-1:0] wd);
    bus.r_en = en; bus.r_dout = dout; bus.r_le = le; bus.r_sel = sel;
    bus.r_err_clr = clr; bus.ti_we = we; bus.ti_re = re;
    bus.ti_idx = idx; bus.ti_wdata = wd;
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [S-1:0] sel);
    drive(0, 0, 0, sel, 0, 0, 0, 0, 0);
  endtask

  task automatic shift_bits(input logic [S-1:0] sel, input logic [W-1:0] data, input int n);
    for (int i = 0; i < n; i++) drive(1, data[W-1-i], 0, sel, 0, 0, 0, 0, 0);
  endtask

  task automatic rpi_write(input logic [S-1:0] sel, input logic [W-1:0] data);
    shift_bits(sel, data, W);
    drive(0, 0, 1, sel, 0, 0, 0, 0, 0);
  endtask

  task automatic ti_write(input logic [S-1:0] idx, input logic [W-1:0] data);
    drive(0, 0, 0, bus.r_sel, 0, 1, 0, idx, data);
  endtask

  task automatic ti_read(input logic [S-1:0] idx);
    drive(0, 0, 0, bus.r_sel, 0, 0, 1, idx, 0);
  endtask

  task automatic err_clear();
    drive(0, 0, 0, bus.r_sel, 1, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] seq;

  initial begin
    r_rst = 1;
    bus.r_en = 0; bus.r_dout = 0; bus.r_le = 0; bus.r_sel = 0; bus.r_err_clr = 0;
    bus.ti_we = 0; bus.ti_re = 0; bus.ti_idx = 0; bus.ti_wdata = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("reset r_din", 32'(bus.r_din), 0);
    check("reset r_err", 32'(bus.r_err), 0);
    check("reset ti_rdata", 32'(bus.ti_rdata), 0);
    check("reset ti_pending", 32'(bus.ti_pending), 0);
    r_rst = 0;
    started = 1;
    idle(0);

    // RPi write of A5 to RD
    rpi_write(TIPI_RD[S-1:0], 8'hA5);
    check("wr pending1", 32'(bus.ti_pending[1]), 1);
    check("wr parity", 32'(bus.r_din), 0);
    ti_read(TIPI_RD[S-1:0]);
    check("wr rdata", 32'(bus.ti_rdata), 32'h A5);
    check("wr pending1 clr", 32'(bus.ti_pending[1]), 0);

    // RPi read of 3C from TD
    ti_write(TIPI_TD[S-1:0], 8'h3C);
    check("rd pending3", 32'(bus.ti_pending[3]), 1);
    seq = '0;
    for (int i = 0; i < W; i++) begin
      drive(1, 0, 0, TIPI_TD[S-1:0], 0, 0, 0, 0, 0);
      seq = {seq[W-2:0], bus.r_din};
    end
    check("rd sequence", 32'(seq), 32'h3C);
    drive(0, 0, 1, TIPI_TD[S-1:0], 0, 0, 0, 0, 0);
    check("rd pending3 clr", 32'(bus.ti_pending[3]), 0);

    // Framing errors
    shift_bits(1, 8'hFF, 5);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
    check("short le err", 32'(bus.r_err), 1);
    err_clear();
    check("err clr", 32'(bus.r_err), 0);
    shift_bits(1, 8'h12, W);
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
    check("overrun err", 32'(bus.r_err), 1);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
    err_clear();

    // Abort on selection change, then clean transfer to reg0
    shift_bits(1, 8'hC3, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("abort err", 32'(bus.r_err), 1);
    err_clear();
    rpi_write(TIPI_RC[S-1:0], 8'h5A);
    ti_read(TIPI_RC[S-1:0]);
    check("after abort rdata", 32'(bus.ti_rdata), 32'h5A);

    // Collision: commit and TI read of the same register together
    rpi_write(1, 8'h11);
    shift_bits(1, 8'h77, W);
    drive(0, 0, 1, 1, 0, 0, 1, 1, 0);
    check("coll rdata old", 32'(bus.ti_rdata), 32'h11);
    check("coll pending", 32'(bus.ti_pending[1]), 1);
    ti_read(1);
    check("coll new value", 32'(bus.ti_rdata), 32'h77);

    // Reset mid-transfer
    ti_write(2, 8'hF0);
    shift_bits(2, 8'h00, 4);
    r_rst = 1; #1;
    check("mid rst r_din", 32'(bus.r_din), 0);
    check("mid rst r_err", 32'(bus.r_err), 0);
    check("mid rst rdata", 32'(bus.ti_rdata), 0);
    check("mid rst pending", 32'(bus.ti_pending), 0);
    @(negedge clk); #1;
    r_rst = 0;
    idle(0);
    rpi_write(0, 8'hFF);
    ti_read(0);
    check("post rst rdata", 32'(bus.ti_rdata), 32'hFF);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [S-1:0] sel;
      sel = bus.r_sel;
      if ($urandom_range(0, 39) == 0) sel = S'($urandom_range(0, N - 1));
      if ($urandom_range(0, 799) == 0) r_rst = 1;
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
            $urandom_range(0, 11) == 0, sel, $urandom_range(0, 19) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            S'($urandom_range(0, N - 1)), W'($urandom_range(0, 255)));
      r_rst = 0;
    end

    idle(bus.r_sel);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
